// File: rtl/i2s_tx_stereo.sv
// ---------------------------------------------------------------------------
// i2s_tx_stereo
//   Stereo Philips-I2S transmitter for the Pmod I2S2 (CS4344) DAC.
//   One free-running frame counter generates MCLK, SCLK and LRCK. Left/right
//   samples arrive through a valid/ready handshake into a one-pair holding
//   register and are serialised MSB-first, one SCLK after each LRCK edge,
//   in 32-bit slots with zero padding.
//
// Ports:
//   clk_in            system clock
//   rst_in            synchronous active-high reset
//   sample_left_in    left sample, two's complement
//   sample_right_in   right sample, two's complement
//   sample_valid_in   sample pair valid
//   sample_ready_out  holding register empty (pair taken on valid && ready)
//   mono_in           1 = right slot carries the left sample
//   mute_in           1 = frame transmits zeros
//   underrun_out      one-cycle pulse when a frame starts with no new pair
//   mclk_out          master clock
//   lrck_out          word select, 0 = left, 1 = right
//   sclk_out          serial bit clock
//   sdin_out          serial data
// ---------------------------------------------------------------------------
module i2s_tx_stereo #(
  parameter int SAMPLE_WIDTH    = 24,
  parameter int MCLK_DIV        = 4,
  parameter int MCLK_LRCK_RATIO = 256
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_left_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_right_in,
  input  logic                    sample_valid_in,
  output logic                    sample_ready_out,
  input  logic                    mono_in,
  input  logic                    mute_in,
  output logic                    underrun_out,
  output logic                    mclk_out,
  output logic                    lrck_out,
  output logic                    sclk_out,
  output logic                    sdin_out
);

  localparam int FRAME_CLKS = MCLK_DIV * MCLK_LRCK_RATIO;
  localparam int SCLK_CLKS  = FRAME_CLKS / 64;
  localparam int FW         = $clog2(FRAME_CLKS);
  localparam int MB         = $clog2(MCLK_DIV);
  localparam int SB         = $clog2(SCLK_CLKS);
  localparam int SW         = SAMPLE_WIDTH;

  localparam logic [FW-1:0] FCNT_LAST    = FW'(FRAME_CLKS - 1);
  localparam logic [FW-1:0] FCNT_PRELAST = FW'(FRAME_CLKS - 2);

  logic [FW-1:0] r_fcnt;
  logic          r_mclk, r_sclk, r_lrck, r_sdin;
  logic          r_underrun, r_ready, r_full;
  logic [SW-1:0] r_hold_l, r_hold_r;
  logic [SW-1:0] r_last_l, r_last_r;
  logic [SW-1:0] r_frm_l,  r_frm_r;

  logic          w_accept, w_load, w_full_nxt;
  logic [SW-1:0] w_src_l, w_src_r, w_word;
  logic [4:0]    w_pos;
  logic [31:0]   w_slot;
  logic          w_bit;

  assign w_accept   = sample_valid_in && r_ready;
  assign w_load     = (r_fcnt == FCNT_LAST);
  // A pair accepted on the load cycle is not seen by that load; it stays
  // in holding for the following frame.
  assign w_full_nxt = w_accept || (r_full && !w_load);

  assign w_src_l = r_full ? r_hold_l : r_last_l;
  assign w_src_r = r_full ? r_hold_r : r_last_r;

  // Slot image: bit 31 is the I2S delay bit, the word follows MSB-first,
  // then zero padding. Position p within the slot selects bit 31-p.
  assign w_pos  = r_fcnt[FW-2:SB];
  assign w_word = r_fcnt[FW-1] ? r_frm_r : r_frm_l;
  assign w_slot = 32'({1'b0, w_word}) << (31 - SW);
  assign w_bit  = w_slot[~w_pos];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_fcnt     <= '0;
      r_mclk     <= 1'b0;
      r_sclk     <= 1'b0;
      r_lrck     <= 1'b0;
      r_sdin     <= 1'b0;
      r_underrun <= 1'b0;
      r_ready    <= 1'b1;
      r_full     <= 1'b0;
      r_hold_l   <= '0;
      r_hold_r   <= '0;
      r_last_l   <= '0;
      r_last_r   <= '0;
      r_frm_l    <= '0;
      r_frm_r    <= '0;
    end else begin
      r_fcnt <= r_fcnt + 1'b1;
      r_mclk <= r_fcnt[MB-1];
      r_sclk <= r_fcnt[SB-1];
      r_lrck <= r_fcnt[FW-1];

      // Change data together with the SCLK falling edge.
      if (r_fcnt[SB-1:0] == '0)
        r_sdin <= w_bit;

      // Registered one cycle early so the pulse coincides with the load cycle.
      r_underrun <= (r_fcnt == FCNT_PRELAST) && !w_full_nxt;

      r_full  <= w_full_nxt;
      r_ready <= !w_full_nxt;

      if (w_accept) begin
        r_hold_l <= sample_left_in;
        r_hold_r <= sample_right_in;
      end

      if (w_load) begin
        if (r_full) begin
          r_last_l <= r_hold_l;
          r_last_r <= r_hold_r;
        end
        r_frm_l <= mute_in ? '0 : w_src_l;
        r_frm_r <= mute_in ? '0 : (mono_in ? w_src_l : w_src_r);
      end
    end
  end

  assign mclk_out         = r_mclk;
  assign sclk_out         = r_sclk;
  assign lrck_out         = r_lrck;
  assign sdin_out         = r_sdin;
  assign underrun_out     = r_underrun;
  assign sample_ready_out = r_ready;

endmodule

// File: tb/tb_i2s_tx_stereo.sv
module tb_i2s_tx_stereo;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] s_l, s_r;
  logic        s_valid, mono, mute;
  logic        ready, underrun, mclk, lrck, sclk, sdin;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rises   = 0;
  logic prev_sclk = 1'b0;

  // Pair currently on the wire and pair the next frame load will send.
  logic [23:0] cur_l = '0, cur_r = '0, nxt_l = '0, nxt_r = '0;
  // Whether the frame in progress should end with an underrun pulse.
  logic und_en = 1'b1;

  always #5 clk = ~clk;

  i2s_tx_stereo dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .sample_left_in   (s_l),
    .sample_right_in  (s_r),
    .sample_valid_in  (s_valid),
    .sample_ready_out (ready),
    .mono_in          (mono),
    .mute_in          (mute),
    .underrun_out     (underrun),
    .mclk_out         (mclk),
    .lrck_out         (lrck),
    .sclk_out         (sclk),
    .sdin_out         (sdin)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Expected serial bit for slot index k (0..63) of a frame carrying l/r.
  function automatic logic exp_bit(input logic [23:0] l, input logic [23:0] r, input int k);
    int p;
    logic [23:0] w;
    p = k % 32;
    w = (k < 32) ? l : r;
    if (p >= 1 && p <= 24) return w[24-p];
    return 1'b0;
  endfunction

  // One clock edge; outputs after edge n reflect counter value n-1.
  task automatic step();
    int fo;
    @(posedge clk);
    cyc++;
    if (cyc % 1024 == 0) begin
      cur_l  = nxt_l;
      cur_r  = nxt_r;
      und_en = 1'b1;
    end
    @(negedge clk);
    fo = (cyc - 1) % 1024;
    chk("mclk", mclk, ((fo >> 1) & 1) == 1);
    chk("sclk", sclk, ((fo >> 3) & 1) == 1);
    chk("lrck", lrck, ((fo >> 9) & 1) == 1);
    chk("sdin", sdin, exp_bit(cur_l, cur_r, fo >> 4));
    chk("underrun", underrun, und_en && (cyc % 1024 == 1023));
    if (sclk && !prev_sclk) rises++;
    prev_sclk = sclk;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mclk"}, mclk, 1'b0);
    chk({tag, "_lrck"}, lrck, 1'b0);
    chk({tag, "_sclk"}, sclk, 1'b0);
    chk({tag, "_sdin"}, sdin, 1'b0);
    chk({tag, "_underrun"}, underrun, 1'b0);
    chk({tag, "_ready"}, ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; mono = 1'b0; mute = 1'b0;
    s_l = '0; s_r = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    cyc = 0;

    // Frame 0: idle, then accept a pair before the first load.
    run_to(100);
    chk("ready_idle", ready, 1'b1);
    s_l = 24'hA5F00F; s_r = 24'h3C0001; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    chk("ready_after_accept", ready, 1'b0);
    und_en = 1'b0; nxt_l = 24'hA5F00F; nxt_r = 24'h3C0001;
    // Offered while ready is low: must be ignored.
    s_l = 24'h111111; s_r = 24'h222222; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    chk("ready_still_low", ready, 1'b0);
    run_to(1023);
    chk("ready_before_load", ready, 1'b0);
    step();
    chk("ready_after_load", ready, 1'b1);
    chk_int("sclk_rises_frame0", rises, 64);

    // Frame 1 sends A5F00F/3C0001 and ends with an underrun.
    run_to(2048);
    chk_int("sclk_rises_frame1", rises, 128);

    // Frame 2 repeats; valid held continuously from here.
    s_l = 24'h123456; s_r = 24'h654321; s_valid = 1'b1;
    step();
    chk("cont_ready_low", ready, 1'b0);
    und_en = 1'b0; nxt_l = 24'h123456; nxt_r = 24'h654321;
    s_l = 24'h0FEDCB; s_r = 24'hABCDEF;
    run_to(3071);
    chk("cont_ready_pre_load", ready, 1'b0);
    step();
    chk("cont_ready_post_load", ready, 1'b1);
    step();
    chk("cont_second_accept", ready, 1'b0);
    und_en = 1'b0; nxt_l = 24'h0FEDCB; nxt_r = 24'hABCDEF;
    s_valid = 1'b0;
    run_to(4096);

    // Mono.
    mono = 1'b1;
    s_l = 24'h800000; s_r = 24'h7FFFFF; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    und_en = 1'b0; nxt_l = 24'h800000; nxt_r = 24'h800000;
    run_to(5120);
    mono = 1'b0;

    // Mute: holding still consumed, last pair still updated.
    mute = 1'b1;
    s_l = 24'h5A5A5A; s_r = 24'hC3C3C3; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    chk("mute_ready_low", ready, 1'b0);
    und_en = 1'b0; nxt_l = '0; nxt_r = '0;
    run_to(6143);
    step();
    chk("mute_ready_post_load", ready, 1'b1);
    run_to(7167);
    mute = 1'b0;
    nxt_l = 24'h5A5A5A; nxt_r = 24'hC3C3C3;
    step();

    // Fill holding, then reset at counter value 600.
    run_to(7200);
    s_l = 24'h010203; s_r = 24'h040506; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    und_en = 1'b0;
    chk("pre_reset_ready", ready, 1'b0);
    run_to(7768);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("midreset");
    rst = 1'b0;
    cyc = 0; rises = 0; prev_sclk = 1'b0;
    cur_l = '0; cur_r = '0; nxt_l = '0; nxt_r = '0; und_en = 1'b1;

    // Counter restarts from 0, holding is empty, last pair cleared.
    run_to(1023);
    chk("post_reset_ready", ready, 1'b1);
    chk("post_reset_underrun", underrun, 1'b1);
    // Accept on the load cycle itself: repeat now, send next frame.
    s_l = 24'h0A0B0C; s_r = 24'h0D0E0F; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    chk("sim_accept_ready", ready, 1'b0);
    und_en = 1'b0; nxt_l = 24'h0A0B0C; nxt_r = 24'h0D0E0F;
    run_to(3072);
    chk_int("post_reset_rises", rises, 192);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
